// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the digit-serial BCD adder.
//   state_t    : controller states (IDLE / ADD / DONE)
//   BCD_MAX    : largest legal BCD digit value
//   BCD_BASE   : decimal radix used for digit correction
//   idx_width(): digit-counter width, never narrower than 1 bit
package bcd_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned BCD_MAX  = 9;
  localparam int unsigned BCD_BASE = 10;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit combinational BCD add with decimal correction.
// Ports:
//   i_cin     : carry in
//   i_a, i_b  : 4-bit BCD digits
//   o_cout    : decimal carry out (raw sum >= 10)
//   o_s       : corrected 4-bit sum digit
//   o_invalid : either input digit above 9 (sum is still produced)
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic       i_cin,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic       o_cout,
  output logic [3:0] o_s,
  output logic       o_invalid
);

  logic [4:0] w_raw;
  logic [3:0] w_corr;

  always_comb begin
    w_raw     = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
    // (raw - 10) modulo 16 only needs the low nibble of raw
    w_corr    = w_raw[3:0] - 4'(BCD_BASE);
    o_s       = w_raw[3:0];
    o_cout    = 1'b0;
    if (w_raw >= 5'(BCD_BASE)) begin
      o_s    = w_corr;
      o_cout = 1'b1;
    end
    o_invalid = (i_a > 4'(BCD_MAX)) || (i_b > 4'(BCD_MAX));
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit per clock, LSD first.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_start      : start request, accepted in IDLE or DONE
//   i_cin        : carry into digit 0
//   i_a, i_b     : packed BCD operands, digit 0 in [3:0]
//   o_s          : registered BCD sum
//   o_cout       : registered carry out of the top digit
//   o_busy       : addition in progress
//   o_done       : one-cycle result-valid pulse
//   o_invalid    : a non-BCD digit was seen in the current operation
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int unsigned NDIGITS = 4,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_cin,
  input  logic [NDIGITS*DIGIT_W-1:0] i_a,
  input  logic [NDIGITS*DIGIT_W-1:0] i_b,
  output logic [NDIGITS*DIGIT_W-1:0] o_s,
  output logic                       o_cout,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_invalid
);

  localparam int unsigned W     = NDIGITS * DIGIT_W;
  localparam int unsigned IDX_W = idx_width(NDIGITS);

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_s;
  logic               r_carry;
  logic               r_cout;
  logic               r_invalid;
  logic [IDX_W-1:0]   r_idx;

  logic [DIGIT_W-1:0] w_dig_a;
  logic [DIGIT_W-1:0] w_dig_b;
  logic [DIGIT_W-1:0] w_dig_s;
  logic               w_dig_cout;
  logic               w_dig_inv;
  logic               w_last;
  logic               w_accept;

  assign w_dig_a  = r_a[int'(r_idx)*DIGIT_W +: DIGIT_W];
  assign w_dig_b  = r_b[int'(r_idx)*DIGIT_W +: DIGIT_W];
  assign w_last   = (r_idx == IDX_W'(NDIGITS - 1));
  assign w_accept = i_start && ((r_state == IDLE) || (r_state == DONE));

  bcd_digit_add u_digit (
    .i_cin     (r_carry),
    .i_a       (w_dig_a),
    .i_b       (w_dig_b),
    .o_cout    (w_dig_cout),
    .o_s       (w_dig_s),
    .o_invalid (w_dig_inv)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = ADD;
      ADD:     if (w_last)  w_next = DONE;
      DONE:    w_next = i_start ? ADD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    o_busy = (r_state == ADD);
    o_done = (r_state == DONE);
  end

  // Operand latch and per-digit accumulation
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_s       <= '0;
      r_carry   <= 1'b0;
      r_cout    <= 1'b0;
      r_invalid <= 1'b0;
      r_idx     <= '0;
    end else if (w_accept) begin
      r_a       <= i_a;
      r_b       <= i_b;
      r_carry   <= i_cin;
      r_s       <= '0;
      r_cout    <= 1'b0;
      r_invalid <= 1'b0;
      r_idx     <= '0;
    end else if (r_state == ADD) begin
      r_s[int'(r_idx)*DIGIT_W +: DIGIT_W] <= w_dig_s;
      r_carry <= w_dig_cout;
      if (w_dig_inv) r_invalid <= 1'b1;
      if (w_last) r_cout <= w_dig_cout;
      else        r_idx  <= r_idx + IDX_W'(1);
    end
  end

  assign o_s       = r_s;
  assign o_cout    = r_cout;
  assign o_invalid = r_invalid;

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [15:0] a, b, s;
  logic        cout, busy, done, inv;

  logic        s1_start, s1_cin;
  logic [3:0]  s1_a, s1_b, s1_s;
  logic        s1_cout, s1_busy, s1_done, s1_inv;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.NDIGITS(4), .DIGIT_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cin(cin),
    .i_a(a), .i_b(b), .o_s(s), .o_cout(cout),
    .o_busy(busy), .o_done(done), .o_invalid(inv)
  );

  bcd_serial_adder #(.NDIGITS(1), .DIGIT_W(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(s1_start), .i_cin(s1_cin),
    .i_a(s1_a), .i_b(s1_b), .o_s(s1_s), .o_cout(s1_cout),
    .o_busy(s1_busy), .o_done(s1_done), .o_invalid(s1_inv)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb2, input logic tc);
    a = ta; b = tb2; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait: returns 20 if Done never appears
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      lat++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b1;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_checks++; if ({s, cout, inv} !== 18'h0) $display("FAIL reset_outputs: got s=%h cout=%b inv=%b expected all 0", s, cout, inv); else n_pass++;
    start = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    int busy_cnt;
    start_op(16'h1234, 16'h5678, 1'b0);
    lat = 0; busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy) busy_cnt++;
      if (done) break;
      tick();
      lat++;
    end
    n_checks++; if (lat !== 4) $display("FAIL basic_latency: got %0d expected 4", lat); else n_pass++;
    n_checks++; if (busy_cnt !== 4) $display("FAIL basic_busy_cycles: got %0d expected 4", busy_cnt); else n_pass++;
    n_checks++; if (s !== 16'h6912) $display("FAIL basic_sum: got %h expected 6912", s); else n_pass++;
    n_checks++; if (cout !== 1'b0 || inv !== 1'b0) $display("FAIL basic_flags: got cout=%b inv=%b expected 0 0", cout, inv); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_idle_after: got done=%b busy=%b expected 0 0", done, busy); else n_pass++;
    n_checks++; if (s !== 16'h6912) $display("FAIL basic_hold: got %h expected 6912", s); else n_pass++;
  endtask

  task automatic test_vectors();
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic        vc [6];
    logic [15:0] es [6];
    logic        ec [6];
    int lat;
    va[0] = 16'h9999; vb[0] = 16'h0001; vc[0] = 1'b0; es[0] = 16'h0000; ec[0] = 1'b1;
    va[1] = 16'h0000; vb[1] = 16'h0000; vc[1] = 1'b1; es[1] = 16'h0001; ec[1] = 1'b0;
    va[2] = 16'h5000; vb[2] = 16'h5000; vc[2] = 1'b0; es[2] = 16'h0000; ec[2] = 1'b1;
    va[3] = 16'h0999; vb[3] = 16'h0001; vc[3] = 1'b0; es[3] = 16'h1000; ec[3] = 1'b0;
    va[4] = 16'h4321; vb[4] = 16'h1234; vc[4] = 1'b1; es[4] = 16'h5556; ec[4] = 1'b0;
    va[5] = 16'h9999; vb[5] = 16'h9999; vc[5] = 1'b1; es[5] = 16'h9999; ec[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i], vc[i]);
      wait_done(lat);
      n_checks++;
      if (lat !== 4 || s !== es[i] || cout !== ec[i] || inv !== 1'b0)
        $display("FAIL vector_%0d: got lat=%0d s=%h cout=%b inv=%b expected lat=4 s=%h cout=%b inv=0",
                 i, lat, s, cout, inv, es[i], ec[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_invalid();
    int lat;
    start_op(16'h00A0, 16'h0000, 1'b0);
    wait_done(lat);
    n_checks++; if (inv !== 1'b1) $display("FAIL invalid_set: got %b expected 1", inv); else n_pass++;
    n_checks++; if (s !== 16'h0100 || cout !== 1'b0) $display("FAIL invalid_sum: got s=%h cout=%b expected 0100 0", s, cout); else n_pass++;
    tick();
    n_checks++; if (inv !== 1'b1) $display("FAIL invalid_hold: got %b expected 1", inv); else n_pass++;
    start_op(16'h0000, 16'h0000, 1'b0);
    n_checks++; if (inv !== 1'b0) $display("FAIL invalid_clear_on_start: got %b expected 0", inv); else n_pass++;
    wait_done(lat);
    n_checks++; if (inv !== 1'b0 || s !== 16'h0000) $display("FAIL invalid_next_op: got inv=%b s=%h expected 0 0000", inv, s); else n_pass++;
    tick();
  endtask

  task automatic test_ignore_start();
    int lat;
    start_op(16'h1234, 16'h5678, 1'b0);
    lat = 0;
    tick(); lat++;
    a = 16'h9999; b = 16'h9999; cin = 1'b1; start = 1'b1;
    tick(); lat++;
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done) break;
      tick();
      lat++;
    end
    n_checks++; if (lat !== 4) $display("FAIL ignore_latency: got %0d expected 4", lat); else n_pass++;
    n_checks++; if (s !== 16'h6912 || cout !== 1'b0) $display("FAIL ignore_sum: got s=%h cout=%b expected 6912 0", s, cout); else n_pass++;
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL ignore_no_queue: got busy=%b done=%b expected 0 0", busy, done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    tick();
    a = 16'h0001; b = 16'h0002;
    wait_done(lat);
    n_checks++; if (lat !== 4 || s !== 16'h6912) $display("FAIL b2b_first: got lat=%0d s=%h expected 4 6912", lat, s); else n_pass++;
    wait_done(lat);
    n_checks++; if (lat !== 5 || s !== 16'h0003) $display("FAIL b2b_second: got lat=%0d s=%h expected 5 0003", lat, s); else n_pass++;
    start = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_stop: got busy=%b done=%b expected 0 0", busy, done); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    start_op(16'h1234, 16'h5678, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({s, cout, inv, busy, done} !== 20'h0)
      $display("FAIL midreset_outputs: got s=%h cout=%b inv=%b busy=%b done=%b expected all 0", s, cout, inv, busy, done);
    else n_pass++;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (done || busy) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) $display("FAIL midreset_no_done: got %0d active cycles expected 0", seen); else n_pass++;
    start_op(16'h9999, 16'h9999, 1'b0);
    wait_done(lat);
    n_checks++; if (lat !== 4 || s !== 16'h9998 || cout !== 1'b1) $display("FAIL midreset_recover: got lat=%0d s=%h cout=%b expected 4 9998 1", lat, s, cout); else n_pass++;
    tick();
  endtask

  task automatic test_single_digit();
    s1_a = 4'd7; s1_b = 4'd5; s1_cin = 1'b0; s1_start = 1'b1;
    tick();
    s1_start = 1'b0;
    n_checks++; if (s1_busy !== 1'b1 || s1_done !== 1'b0) $display("FAIL single_add: got busy=%b done=%b expected 1 0", s1_busy, s1_done); else n_pass++;
    tick();
    n_checks++; if (s1_done !== 1'b1 || s1_s !== 4'd2 || s1_cout !== 1'b1 || s1_inv !== 1'b0)
      $display("FAIL single_done: got done=%b s=%h cout=%b inv=%b expected 1 2 1 0", s1_done, s1_s, s1_cout, s1_inv);
    else n_pass++;
    tick();
    n_checks++; if (s1_done !== 1'b0 || s1_busy !== 1'b0) $display("FAIL single_idle: got done=%b busy=%b expected 0 0", s1_done, s1_busy); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cin = 1'b0; a = '0; b = '0;
    s1_start = 1'b0; s1_cin = 1'b0; s1_a = '0; s1_b = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_invalid();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_single_digit();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
